bist_response_analyzer: RTL and testbench
=========================================

Name: bist_response_analyzer

Overview:
- Downstream response stage of the BIST datapath: compacts the scan chain serial output plus the two functional outputs (synced_d, sync_err_d) into a multiple-input signature register (MISR).
- On the controller's finish pulse it compares the signature against a golden value and raises a sticky pass/fail verdict.
- Replaces the free-running MISR plus separate comparator pair with one sequenced block.
- Has explicit start/finish handshaking with the BIST controller, a compaction cycle counter and overflow protection.

Parameters:
- W, 8, signature width (≥4).
- POLY, 8'h1D, MISR feedback polynomial (taps XORed when MSB shifts out).
- SEED, 8'h00, signature value after reset/start.
- GOLDEN, 8'hA5, expected fault-free signature.
- MAX_CYCLES, 16'hFFFF, compaction cycle limit; reaching it forces fail.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse from BIST controller: begin/restart compaction.
- en  in  1  compaction enable (BIST mode/scan enable); MISR updates only when 1.
- finish  in  1  one-cycle pulse from BIST controller: test sequence ended.
- e0  in  1  scan chain serial output.
- e1  in  1  synced_d from circuit under test.
- e2  in  1  sync_err_d from circuit under test.
- busy  out  1  high while compacting.
- done  out  1  verdict valid.
- pass_fail  out  1  1 = signature matched and no overflow; meaningful only when done=1.
- sig  out  W  current signature (debug).
- cycles  out  16  number of compacted cycles.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values (RST=0, asynchronous): state=IDLE, sig=SEED, cycles=0, busy=0, done=0, pass_fail=0, ovf=0.
- MISR update: sig_next = {sig[W-2:0],1'b0} ^ (sig[W-1] ? POLY : 0) ^ {{W-3{0}}, e2, e1, e0}. e0 goes to bit0, e1 to bit1, e2 to bit2.
- FSM states: IDLE, COMPACT, COMPARE, DONE.
- IDLE: sig held. start=1 → sig<=SEED, cycles<=0, ovf<=0, done<=0, go COMPACT. finish is ignored.
- COMPACT: busy=1.
  - When en=1: sig<=sig_next and cycles<=cycles+1.
  - When en=0: sig and cycles hold.
  - finish=1 → go COMPARE. The data in the finish cycle is still compacted if en=1.
  - start=1 → restart: sig<=SEED, cycles<=0, stay in COMPACT. start has priority over finish when both are high.
  - cycles reaching MAX_CYCLES with en=1 → ovf<=1, go COMPARE; no further compaction.
- COMPARE (exactly one cycle): pass_fail<=(sig==GOLDEN)&&!ovf, done<=1, busy<=0, go DONE.
- Verdict latency: finish sampled at edge k; done and pass_fail are valid after edge k+1.
- DONE: done and pass_fail are sticky; sig and cycles frozen. start=1 → clear done and pass_fail, reload SEED, go COMPACT. finish is ignored.
- Reset mid-operation: immediate return to reset values; no partial verdict survives.
- cycles never wraps; it saturates at MAX_CYCLES.

Optional Feature:
- Macro: MISR_DUMP_EN.
- Defined:
  - Adds output ports dump_bit (1) and dump_valid (1), and a DUMP state between COMPARE and DONE.
  - In DUMP the signature shifts out MSB first over W cycles with dump_valid=1. done asserts at the end of DUMP, so verdict latency = W+1 edges after finish.
  - start during DUMP aborts the dump and restarts compaction.
- Undefined: no dump ports, no DUMP state; COMPARE goes directly to DONE.

Decomposition:
- Shared package bist_pkg holds:
  - FSM state enum (IDLE, COMPACT, COMPARE, DUMP, DONE).
  - Default POLY, SEED and GOLDEN constants.
  - CYCLE_W=16 constant.
- One sub-module, misr_core: parameterised W/POLY/SEED; ports CLK, RST, load, shift, 3-bit data in, W-bit signature out. FSM and comparison stay in the parent.

Test Plan:
- Reset then start, en=1, e=000 for 10 cycles, finish, GOLDEN=8'h00 → sig=8'h00, cycles=10, done=1 and pass_fail=1 two edges after finish.
- Start, one cycle e=001 then three cycles e=000 (en=1), finish, GOLDEN=8'h08 → sig=8'h08, pass_fail=1. Repeat with GOLDEN=8'h09 → pass_fail=0.
- Start, en toggles 1,0,1,0 with e=111 → cycles=2; sig advances only on en=1 cycles.
- MAX_CYCLES=5, en=1 held, no finish → ovf after 5 compacted cycles; done=1 and pass_fail=0 even when sig==GOLDEN.
- start and finish asserted in the same COMPACT cycle → restart wins, sig=SEED, still busy. RST pulled low mid-COMPACT → all outputs at reset values immediately.
- MISR_DUMP_EN defined, sig=8'hA5 at finish → dump_bit sequence 1,0,1,0,0,1,0,1 with dump_valid=1 for 8 cycles, then done=1.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST response analyzer: FSM states, default MISR
// constants and the compaction cycle counter width.
package bist_pkg;

  localparam int CYCLE_W = 16;

  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'hA5;

  // DUMP is only entered when the signature dump option is built in.
  typedef enum logic [2:0] {
    IDLE,
    COMPACT,
    COMPARE,
    DUMP,
    DONE
  } state_t;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: e0/e1/e2 fold into bits 0..2 each shift,
// with POLY fed back whenever the MSB leaves the register.
module misr_core
  import bist_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEF_POLY),
  parameter logic [W-1:0] SEED = W'(DEF_SEED)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         shift,
  input  logic [2:0]   data,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_next;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ {{(W-3){1'b0}}, data};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: sequences MISR compaction between start/finish pulses
// and latches a sticky pass/fail verdict. Define MISR_DUMP_EN to add a serial signature dump.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int                 W          = 8,
  parameter logic [W-1:0]       POLY       = W'(DEF_POLY),
  parameter logic [W-1:0]       SEED       = W'(DEF_SEED),
  parameter logic [W-1:0]       GOLDEN     = W'(DEF_GOLDEN),
  parameter logic [CYCLE_W-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               en,
  input  logic               finish,
  input  logic               e0,
  input  logic               e1,
  input  logic               e2,
  output logic               busy,
  output logic               done,
  output logic               pass_fail,
  output logic [W-1:0]       sig,
  output logic [CYCLE_W-1:0] cycles
`ifdef MISR_DUMP_EN
  ,
  output logic               dump_bit,
  output logic               dump_valid
`endif
);

  localparam logic [CYCLE_W-1:0] LAST_CYCLE = MAX_CYCLES - CYCLE_W'(1);

  state_t state;
  logic   ovf;
  logic   misr_load;
  logic   misr_shift;
  logic   hit_max;

`ifdef MISR_DUMP_EN
  localparam int            DC_W      = $clog2(W);
  localparam logic [DC_W-1:0] DUMP_LAST = DC_W'(W - 1);

  logic [W-1:0]    dump_sr;
  logic [DC_W-1:0] dump_cnt;

  assign dump_bit = dump_sr[W-1];
`endif

  // start restarts from every state except the single COMPARE cycle, and beats finish.
  always_comb begin
    misr_load  = start && (state != COMPARE);
    misr_shift = (state == COMPACT) && en && !start && (cycles != MAX_CYCLES);
    hit_max    = misr_shift && (cycles == LAST_CYCLE);
  end

  misr_core #(
    .W   (W),
    .POLY(POLY),
    .SEED(SEED)
  ) u_misr (
    .CLK  (CLK),
    .RST  (RST),
    .load (misr_load),
    .shift(misr_shift),
    .data ({e2, e1, e0}),
    .sig  (sig)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cycles    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_fail <= 1'b0;
      ovf       <= 1'b0;
`ifdef MISR_DUMP_EN
      dump_sr    <= '0;
      dump_cnt   <= '0;
      dump_valid <= 1'b0;
`endif
    end else if (misr_load) begin
      state     <= COMPACT;
      cycles    <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass_fail <= 1'b0;
      ovf       <= 1'b0;
`ifdef MISR_DUMP_EN
      dump_valid <= 1'b0;
`endif
    end else begin
      case (state)
        COMPACT: begin
          if (misr_shift) begin
            cycles <= cycles + CYCLE_W'(1);
          end
          if (hit_max) begin
            ovf <= 1'b1;
          end
          // The finish-cycle sample is compacted above before the verdict is taken.
          if (finish || hit_max) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          pass_fail <= (sig == GOLDEN) && !ovf;
          busy      <= 1'b0;
`ifdef MISR_DUMP_EN
          dump_sr    <= sig;
          dump_cnt   <= '0;
          dump_valid <= 1'b1;
          state      <= DUMP;
`else
          done  <= 1'b1;
          state <= DONE;
`endif
        end
`ifdef MISR_DUMP_EN
        DUMP: begin
          dump_sr <= {dump_sr[W-2:0], 1'b0};
          if (dump_cnt == DUMP_LAST) begin
            dump_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            dump_cnt <= dump_cnt + DC_W'(1);
          end
        end
`endif
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Scoreboard bench: three analyzer instances with different GOLDEN/MAX_CYCLES share
// randomized stimulus; a word-list reference model predicts each verdict.
module tb_bist_response_analyzer;

  localparam int N = 3;
  localparam int W = 8;
  localparam logic [7:0] POLY = 8'h1D;
  localparam logic [7:0] GOLD [N] = '{8'h08, 8'h00, 8'h00};
  localparam int         MAXC [N] = '{65535, 65535, 5};

  localparam int P_IDLE = 0;
  localparam int P_COMP = 1;
  localparam int P_CMP  = 2;
  localparam int P_DUMP = 3;
  localparam int P_DONE = 4;

  typedef struct {
    logic [7:0]  sig;
    logic [15:0] cycles;
    logic        pass;
  } exp_t;

  logic CLK = 1'b0;
  logic RST, start, en, finish, e0, e1, e2;

  logic        busy_w [N];
  logic        done_w [N];
  logic        pf_w   [N];
  logic [7:0]  sig_w  [N];
  logic [15:0] cyc_w  [N];
`ifdef MISR_DUMP_EN
  logic        db_w   [N];
  logic        dv_w   [N];
`endif

  int checks   = 0;
  int failures = 0;

  exp_t       exp_q [N][$];
  logic [2:0] words [N][$];
  int         phase     [N];
  int         dump_left [N];
  bit         ovf_m     [N];

  always #5 CLK = ~CLK;

  bist_response_analyzer #(.GOLDEN(8'h08)) dut0 (
    .CLK(CLK), .RST(RST), .start(start), .en(en), .finish(finish),
    .e0(e0), .e1(e1), .e2(e2), .busy(busy_w[0]), .done(done_w[0]),
    .pass_fail(pf_w[0]), .sig(sig_w[0]), .cycles(cyc_w[0])
`ifdef MISR_DUMP_EN
    , .dump_bit(db_w[0]), .dump_valid(dv_w[0])
`endif
  );

  bist_response_analyzer #(.GOLDEN(8'h00)) dut1 (
    .CLK(CLK), .RST(RST), .start(start), .en(en), .finish(finish),
    .e0(e0), .e1(e1), .e2(e2), .busy(busy_w[1]), .done(done_w[1]),
    .pass_fail(pf_w[1]), .sig(sig_w[1]), .cycles(cyc_w[1])
`ifdef MISR_DUMP_EN
    , .dump_bit(db_w[1]), .dump_valid(dv_w[1])
`endif
  );

  bist_response_analyzer #(.GOLDEN(8'h00), .MAX_CYCLES(16'd5)) dut2 (
    .CLK(CLK), .RST(RST), .start(start), .en(en), .finish(finish),
    .e0(e0), .e1(e1), .e2(e2), .busy(busy_w[2]), .done(done_w[2]),
    .pass_fail(pf_w[2]), .sig(sig_w[2]), .cycles(cyc_w[2])
`ifdef MISR_DUMP_EN
    , .dump_bit(db_w[2]), .dump_valid(dv_w[2])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Signature as polynomial arithmetic over GF(2): acc = acc*x mod (x^8+POLY) + word.
  task automatic model_verdict(input int i);
    logic [8:0] acc;
    exp_t       e;
    acc = '0;
    for (int k = 0; k < words[i].size(); k++) begin
      acc = {acc[7:0], 1'b0};
      if (acc[8]) acc = acc ^ {1'b1, POLY};
      acc = acc ^ {6'b0, words[i][k]};
    end
    e.sig    = acc[7:0];
    e.cycles = 16'(words[i].size());
    e.pass   = (e.sig == GOLD[i]) && !ovf_m[i];
    exp_q[i].push_back(e);
    phase[i] = P_DONE;
  endtask

  task automatic model_step(input int i, input logic s, input logic n, input logic f,
                            input logic [2:0] ev);
    bit ovf;
    case (phase[i])
      P_IDLE, P_DONE: begin
        if (s) begin
          words[i].delete();
          phase[i] = P_COMP;
        end
      end
      P_COMP: begin
        if (s) begin
          words[i].delete();
        end else begin
          ovf = 1'b0;
          if (n) begin
            words[i].push_back(ev);
            ovf = (words[i].size() == MAXC[i]);
          end
          if (f || ovf) begin
            ovf_m[i] = ovf;
            phase[i] = P_CMP;
          end
        end
      end
      P_CMP: begin
`ifdef MISR_DUMP_EN
        phase[i]     = P_DUMP;
        dump_left[i] = W;
`else
        model_verdict(i);
`endif
      end
      P_DUMP: begin
        if (s) begin
          words[i].delete();
          phase[i] = P_COMP;
        end else begin
          dump_left[i]--;
          if (dump_left[i] == 0) model_verdict(i);
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      words[i].delete();
      phase[i]     = P_IDLE;
      dump_left[i] = 0;
      ovf_m[i]     = 1'b0;
    end
  endtask

  // One clock of stimulus; busy is expected while compacting and during the COMPARE cycle.
  task automatic cyc(input logic s, input logic n, input logic f, input logic [2:0] ev);
    start  = s;
    en     = n;
    finish = f;
    {e2, e1, e0} = ev;
    for (int i = 0; i < N; i++) model_step(i, s, n, f, ev);
    @(posedge CLK);
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("dut%0d_busy", i), 32'(busy_w[i]),
            32'((phase[i] == P_COMP) || (phase[i] == P_CMP)));
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_dut%0d_busy", tag, i), 32'(busy_w[i]), 32'd0);
      check($sformatf("%s_dut%0d_done", tag, i), 32'(done_w[i]), 32'd0);
      check($sformatf("%s_dut%0d_pass_fail", tag, i), 32'(pf_w[i]), 32'd0);
      check($sformatf("%s_dut%0d_sig", tag, i), 32'(sig_w[i]), 32'h00);
      check($sformatf("%s_dut%0d_cycles", tag, i), 32'(cyc_w[i]), 32'd0);
    end
  endtask

  // Monitor: a rising done is the DUT presenting a verdict; pop and compare.
  logic       prev_done [N];
  logic       prev_dv   [N];
  logic [7:0] dump_acc  [N];
  int         dump_n    [N];
  exp_t       mon_e;

  always @(negedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (!RST) begin
        prev_done[i] = 1'b0;
        prev_dv[i]   = 1'b0;
        dump_n[i]    = 0;
      end else begin
`ifdef MISR_DUMP_EN
        if (dv_w[i]) begin
          if (!prev_dv[i]) dump_n[i] = 0;
          dump_acc[i] = {dump_acc[i][6:0], db_w[i]};
          dump_n[i]++;
        end
        prev_dv[i] = dv_w[i];
`endif
        if (done_w[i] && !prev_done[i]) begin
          check($sformatf("dut%0d_verdict_expected", i), 32'(exp_q[i].size() > 0), 32'd1);
          if (exp_q[i].size() > 0) begin
            mon_e = exp_q[i].pop_front();
            check($sformatf("dut%0d_sig", i), 32'(sig_w[i]), 32'(mon_e.sig));
            check($sformatf("dut%0d_cycles", i), 32'(cyc_w[i]), 32'(mon_e.cycles));
            check($sformatf("dut%0d_pass_fail", i), 32'(pf_w[i]), 32'(mon_e.pass));
`ifdef MISR_DUMP_EN
            check($sformatf("dut%0d_dump_len", i), 32'(dump_n[i]), 32'(W));
            check($sformatf("dut%0d_dump_bits", i), 32'(dump_acc[i]), 32'(mon_e.sig));
`endif
          end
        end
        prev_done[i] = done_w[i];
      end
    end
  end

  initial begin
    int len;
    int gap;
    start = 1'b0; en = 1'b0; finish = 1'b0; {e2, e1, e0} = 3'b000;
    RST = 1'b1;
    model_reset();
    #1 RST = 1'b0;
    #2 check_reset_values("reset");
    #9 RST = 1'b1;
    @(posedge CLK);
    #1;

    // Ten all-zero words: dut1 matches 8'h00; dut2 overflows after five words.
    cyc(1, 0, 0, 3'b000);
    repeat (10) cyc(0, 1, 0, 3'b000);
    cyc(0, 0, 1, 3'b000);
    repeat (3) cyc(0, 0, 0, 3'b000);

    // One e0 pulse then three zero words gives 8'h08 (dut0 passes, dut1 fails).
    cyc(1, 0, 0, 3'b000);
    cyc(0, 1, 0, 3'b001);
    repeat (3) cyc(0, 1, 0, 3'b000);
    cyc(0, 0, 1, 3'b000);
    repeat (3) cyc(0, 0, 0, 3'b000);

    // en gating: only two of four cycles compact.
    cyc(1, 0, 0, 3'b000);
    cyc(0, 1, 0, 3'b111);
    cyc(0, 0, 0, 3'b111);
    cyc(0, 1, 0, 3'b111);
    cyc(0, 0, 0, 3'b111);
    check("en_gate_cycles", 32'(cyc_w[0]), 32'd2);
    cyc(0, 0, 1, 3'b000);
    repeat (3) cyc(0, 0, 0, 3'b000);

    // start and finish together: restart wins.
    cyc(1, 0, 0, 3'b000);
    cyc(0, 1, 0, 3'b101);
    cyc(0, 1, 0, 3'b010);
    cyc(1, 1, 1, 3'b011);
    check("restart_wins_sig", 32'(sig_w[0]), 32'h00);
    check("restart_wins_cycles", 32'(cyc_w[0]), 32'd0);

    // Asynchronous reset mid-compaction.
    cyc(0, 1, 0, 3'b110);
    #3 RST = 1'b0;
    #1 check_reset_values("midreset");
    model_reset();
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;

`ifdef MISR_DUMP_EN
    // Signature 8'hA5 built by feeding its bits MSB first on e0.
    cyc(1, 0, 0, 3'b000);
    for (int k = 7; k >= 0; k--) cyc(0, 1, 0, {2'b00, 1'(8'hA5 >> k)});
    cyc(0, 0, 1, 3'b000);
    check("dump_sig_a5", 32'(sig_w[0]), 32'hA5);
    repeat (W + 3) cyc(0, 0, 0, 3'b000);
`endif

    // Randomized transactions with occasional restarts and stray finish pulses.
    repeat (60) begin
      cyc(1, 1'($urandom), 0, 3'($urandom));
      len = $urandom_range(0, 20);
      for (int k = 0; k < len; k++)
        cyc(($urandom % 25) == 0, ($urandom % 4) != 0, 0, 3'($urandom));
      cyc(0, 1'($urandom), 1, 3'($urandom));
      gap = $urandom_range(1, 12);
      for (int k = 0; k < gap; k++)
        cyc(0, 1'($urandom), ($urandom % 4) == 0, 3'($urandom));
    end

    repeat (W + 4) cyc(0, 0, 0, 3'b000);
    for (int i = 0; i < N; i++)
      check($sformatf("dut%0d_pending_verdicts", i), 32'(exp_q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
